// File: rtl/router_pkg.sv
// router_pkg: shared state type and destination address constants for the
// 1x3 router (router_fsm, synchronizer and register block).
package router_pkg;

   // 3-bit binary state encoding; DECODE_ADDRESS is the reset state (0).
   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      LOAD_PARITY        = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      WAIT_TILL_EMPTY    = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } state_t;

   localparam logic [1:0] ADDR_0       = 2'b00;
   localparam logic [1:0] ADDR_1       = 2'b01;
   localparam logic [1:0] ADDR_2       = 2'b10;
   localparam logic [1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller for the 1x3 router.
// Ports:
//   clk, rstn                 clock, async active-low reset
//   pkt_valid, d_in[1:0]      input byte handshake and header address bits
//   fifo_full                 full flag of the selected FIFO
//   fifo_empty_0..2           empty flags of the three output FIFOs
//   soft_rst_0..2             per-port soft resets
//   parity_done, low_pkt_valid  status from the register block
//   det_addr, lfd_state, ld_state, laf_state, full_state,
//   write_enb_reg, rst_int_reg, busy   Moore-decoded control strobes
module router_fsm
   import router_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       pkt_valid,
   input  logic [1:0] d_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_rst_0,
   input  logic       soft_rst_1,
   input  logic       soft_rst_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       det_addr,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       write_enb_reg,
   output logic       rst_int_reg,
   output logic       busy
);

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_addr;

   // Padded to 4 entries so address 3 indexes a constant 0.
   logic [3:0] w_empty;
   logic [3:0] w_soft;
   logic       w_soft_hit;

   assign w_empty    = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign w_soft     = {1'b0, soft_rst_2, soft_rst_1, soft_rst_0};
   assign w_soft_hit = w_soft[r_addr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= DECODE_ADDRESS;
         r_addr  <= ADDR_0;
      end else begin
         r_state <= w_next;
         if (r_state == DECODE_ADDRESS && pkt_valid)
            r_addr <= d_in;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         DECODE_ADDRESS: begin
            if (pkt_valid && d_in != ADDR_INVALID)
               w_next = w_empty[d_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         end
         WAIT_TILL_EMPTY: begin
            if (w_empty[r_addr])
               w_next = LOAD_FIRST_DATA;
         end
         LOAD_FIRST_DATA: w_next = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)
               w_next = FIFO_FULL_STATE;
            else if (!pkt_valid)
               w_next = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full)
               w_next = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)
               w_next = DECODE_ADDRESS;
            else if (low_pkt_valid)
               w_next = LOAD_PARITY;
            else
               w_next = LOAD_DATA;
         end
         LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         default: w_next = DECODE_ADDRESS;
      endcase
      // Soft reset of the port owning the current packet overrides everything.
      if (r_state != DECODE_ADDRESS && w_soft_hit)
         w_next = DECODE_ADDRESS;
   end

   assign det_addr      = (r_state == DECODE_ADDRESS);
   assign lfd_state     = (r_state == LOAD_FIRST_DATA);
   assign ld_state      = (r_state == LOAD_DATA);
   assign laf_state     = (r_state == LOAD_AFTER_FULL);
   assign full_state    = (r_state == FIFO_FULL_STATE);
   assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
   assign write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                          (r_state == LOAD_AFTER_FULL);
   assign busy          = (r_state != DECODE_ADDRESS) && (r_state != LOAD_DATA);

endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-sequencing controller for the 1x3 router. It watches the incoming byte stream handshake (`pkt_valid`), the per-port FIFO status and the per-port soft resets, and drives the control strobes that the synchronizer, register and FIFO write path consume. It sits between the input port and the router's datapath. One instance per router.

## Interface
Parameters:
- none; widths and encodings are fixed in `router_pkg`.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `pkt_valid`  in  1  high while header and payload bytes are presented; low on the parity byte.
- `d_in`  in  2  destination address, bits [1:0] of the header byte; meaningful while `det_addr` is high.
- `fifo_full`  in  1  full flag of the currently selected FIFO.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2`  in  1 each  empty flags of the three output FIFOs.
- `soft_rst_0`, `soft_rst_1`, `soft_rst_2`  in  1 each  per-port soft reset pulses from the synchronizer.
- `parity_done`  in  1  register block has captured the parity byte.
- `low_pkt_valid`  in  1  register block saw `pkt_valid` fall while the FIFO was full.
- `det_addr`  out  1  header-decode cycle; loads the destination address in the synchronizer.
- `lfd_state`  out  1  header byte being written.
- `ld_state`  out  1  payload byte being written.
- `laf_state`  out  1  byte held during a full stall being written.
- `full_state`  out  1  stalled on a full FIFO.
- `write_enb_reg`  out  1  FIFO write enable request to the synchronizer.
- `rst_int_reg`  out  1  clear the register block's internal parity/status registers.
- `busy`  out  1  the router cannot accept a new input byte this cycle.

## Operation
- States: DECODE_ADDRESS (reset state), LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
- `addr_q[1:0]` is loaded from `d_in` on every cycle where `det_addr & pkt_valid` is high. Reset value is 0.
- DECODE_ADDRESS:
  - `pkt_valid` with `d_in` equal to N (N in 0..2) and `fifo_empty_N` high: go to LOAD_FIRST_DATA.
  - `pkt_valid` with `d_in` equal to N and `fifo_empty_N` low: go to WAIT_TILL_EMPTY.
  - `d_in` equal to 3, or `pkt_valid` low: stay. A header with address 3 is dropped.
- WAIT_TILL_EMPTY: when `fifo_empty[addr_q]` is high, go to LOAD_FIRST_DATA; otherwise stay.
- LOAD_FIRST_DATA: always go to LOAD_DATA.
- LOAD_DATA:
  - `fifo_full` high: go to FIFO_FULL_STATE. This has priority over `pkt_valid`.
  - Otherwise `pkt_valid` low: go to LOAD_PARITY.
  - Otherwise stay.
- FIFO_FULL_STATE: when `fifo_full` is low, go to LOAD_AFTER_FULL; otherwise stay.
- LOAD_AFTER_FULL:
  - `parity_done`: go to DECODE_ADDRESS.
  - Otherwise `low_pkt_valid`: go to LOAD_PARITY.
  - Otherwise: go to LOAD_DATA.
- LOAD_PARITY: always go to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: `fifo_full` high goes to FIFO_FULL_STATE; otherwise go to DECODE_ADDRESS.
- Soft reset: if `soft_rst_N` is high and `addr_q` equals N in any state other than DECODE_ADDRESS, the next state is DECODE_ADDRESS. This overrides every other transition. A soft reset for any other port is ignored.
- Outputs are Moore-decoded from the state only:
  - `det_addr` = DECODE_ADDRESS.
  - `lfd_state` = LOAD_FIRST_DATA.
  - `ld_state` = LOAD_DATA.
  - `laf_state` = LOAD_AFTER_FULL.
  - `full_state` = FIFO_FULL_STATE.
  - `rst_int_reg` = CHECK_PARITY_ERROR.
  - `write_enb_reg` = LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL.
  - `busy` = any state except DECODE_ADDRESS and LOAD_DATA.

## Timing
- Reset: while `rstn` is low, the state is DECODE_ADDRESS and `addr_q` is 0. Output values during reset:
  - `det_addr` = 1.
  - All other outputs = 0.
- Reset takes effect immediately, including in the middle of a packet. The next packet starts from DECODE_ADDRESS.
- Latency: the header is accepted at edge T (DECODE_ADDRESS to LOAD_FIRST_DATA). `lfd_state` is high in cycle T+1. `ld_state` and `write_enb_reg` are high from T+2.
- The first payload byte must be held during the LOAD_FIRST_DATA cycle, because `busy` is high in that state.
- Parity: `pkt_valid` falls in LOAD_DATA at edge P. LOAD_PARITY is active in cycle P+1 and CHECK_PARITY_ERROR in P+2. `det_addr` returns at P+3 when the FIFO is not full.
- Outputs are glitch-free functions of a registered state. No output combinationally depends on any input.

## Structure
- `router_pkg` holds:
  - the state typedef, 3-bit one-per-state binary encoding with DECODE_ADDRESS = 0;
  - `ADDR_0`, `ADDR_1`, `ADDR_2` and `ADDR_INVALID` = 2'b11.
- The synchronizer and the register block import the same address constants from `router_pkg`.
- Single module with no sub-modules. The block has one state register, one address register, next-state logic and output decode.

## Test plan
- Reset, then send a header with `d_in`=01 while `fifo_empty_1`=1, 4 payload bytes, then parity. Required state sequence: DECODE_ADDRESS → LFD → LD×4 → LOAD_PARITY → CHECK_PARITY_ERROR → DECODE_ADDRESS. `write_enb_reg` is high for exactly 5 cycles.
- Send a header to port 2 while `fifo_empty_2`=0 for 6 cycles. Required: `busy`=1 in WAIT_TILL_EMPTY for 6 cycles, then LFD in the cycle after `fifo_empty_2` rises.
- Raise `fifo_full` for 3 cycles during LOAD_DATA. Required: FIFO_FULL_STATE for 3 cycles, then LAF with `laf_state`=1 and `busy`=1. With `parity_done`=0 and `low_pkt_valid`=0 the next state is LD.
- Hold `pkt_valid`=1 with `d_in`=11 for 5 cycles. Required: stays in DECODE_ADDRESS with `write_enb_reg`=0 and `busy`=0 throughout.
- Mid-packet to port 0, pulse `soft_rst_0`. Required: DECODE_ADDRESS on the next edge. A `soft_rst_1` pulse at the same point is ignored.
- Deassert `rstn` asynchronously in FIFO_FULL_STATE. Required: `det_addr`=1 and `full_state`=0 before the next clock edge.
